// File: rtl/ip_tx_arb.sv
// Transmit arbiter: round-robin grant between ICMP reply and UDP sources, forwards the
// granted byte stream to the MAC with one cycle of latency, then inserts an inter-frame gap.
module ip_tx_arb #(
   parameter int unsigned IFG_CYC     = 12,
   parameter int unsigned TIMEOUT_CYC = 4096
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_icmp_req,
   input  logic        i_udp_req,
   input  logic        i_mac_tx_busy,
   output logic        o_icmp_tx_en,
   output logic        o_udp_tx_en,
   input  logic        i_icmp_txsop,
   input  logic        i_icmp_txeop,
   input  logic        i_icmp_txvld,
   input  logic [7:0]  i_icmp_txdata,
   input  logic        i_udp_txsop,
   input  logic        i_udp_txeop,
   input  logic        i_udp_txvld,
   input  logic [7:0]  i_udp_txdata,
   output logic        o_mac_txsop,
   output logic        o_mac_txeop,
   output logic        o_mac_txvld,
   output logic [7:0]  o_mac_txdata,
   output logic        o_tx_abort,
   output logic [15:0] o_tx_frame_len,
   output logic        o_arb_busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_GRANT,
      S_WAIT_SOP,
      S_XFER,
      S_GAP
   } state_t;

   localparam logic [15:0] WD_LIM   = 16'(TIMEOUT_CYC);
   localparam logic [15:0] GAP_LAST = 16'(IFG_CYC - 1);

   state_t      state_q;
   logic        icmp_pend_q, udp_pend_q;
   logic        sel_udp_q, last_udp_q;
   logic [15:0] wd_q, gap_q, len_q;
   logic        icmp_en_q, udp_en_q, abort_q;
   logic        mac_sop_q, mac_eop_q, mac_vld_q;
   logic [7:0]  mac_data_q;
   logic [15:0] frame_len_q;

   logic        sel_sop_d, sel_eop_d, sel_vld_d;
   logic [7:0]  sel_data_d;
   logic [15:0] wd_inc_d, len_inc_d;
   logic        wd_exp_d, pick_udp_d, clr_icmp_d, clr_udp_d;

   always_comb begin
      sel_sop_d  = sel_udp_q ? i_udp_txsop  : i_icmp_txsop;
      sel_eop_d  = sel_udp_q ? i_udp_txeop  : i_icmp_txeop;
      sel_vld_d  = sel_udp_q ? i_udp_txvld  : i_icmp_txvld;
      sel_data_d = sel_udp_q ? i_udp_txdata : i_icmp_txdata;
      wd_inc_d   = wd_q + 16'd1;
      wd_exp_d   = (wd_inc_d == WD_LIM);
      len_inc_d  = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;
      // Both pending: serve the source opposite the one served last.
      pick_udp_d = (icmp_pend_q & udp_pend_q) ? ~last_udp_q : udp_pend_q;
      clr_icmp_d = (state_q == S_GRANT) & ~sel_udp_q;
      clr_udp_d  = (state_q == S_GRANT) &  sel_udp_q;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q     <= S_IDLE;
         icmp_pend_q <= 1'b0;
         udp_pend_q  <= 1'b0;
         sel_udp_q   <= 1'b0;
         last_udp_q  <= 1'b1;
         wd_q        <= 16'd0;
         gap_q       <= 16'd0;
         len_q       <= 16'd0;
         icmp_en_q   <= 1'b0;
         udp_en_q    <= 1'b0;
         abort_q     <= 1'b0;
         mac_sop_q   <= 1'b0;
         mac_eop_q   <= 1'b0;
         mac_vld_q   <= 1'b0;
         mac_data_q  <= 8'd0;
         frame_len_q <= 16'd0;
      end else begin
         icmp_en_q   <= 1'b0;
         udp_en_q    <= 1'b0;
         abort_q     <= 1'b0;
         mac_sop_q   <= 1'b0;
         mac_eop_q   <= 1'b0;
         mac_vld_q   <= 1'b0;
         mac_data_q  <= 8'd0;
         // A new request in the clearing cycle keeps the flag set.
         icmp_pend_q <= i_icmp_req | (icmp_pend_q & ~clr_icmp_d);
         udp_pend_q  <= i_udp_req  | (udp_pend_q  & ~clr_udp_d);

         case (state_q)
            S_IDLE: begin
               if ((icmp_pend_q | udp_pend_q) & ~i_mac_tx_busy) begin
                  sel_udp_q <= pick_udp_d;
                  icmp_en_q <= ~pick_udp_d;
                  udp_en_q  <= pick_udp_d;
                  state_q   <= S_GRANT;
               end
            end
            S_GRANT: begin
               last_udp_q <= sel_udp_q;
               wd_q       <= 16'd0;
               state_q    <= S_WAIT_SOP;
            end
            S_WAIT_SOP: begin
               if (sel_sop_d & sel_vld_d) begin
                  mac_sop_q  <= 1'b1;
                  mac_eop_q  <= sel_eop_d;
                  mac_vld_q  <= 1'b1;
                  mac_data_q <= sel_data_d;
                  len_q      <= 16'd1;
                  wd_q       <= 16'd0;
                  if (sel_eop_d) begin
                     frame_len_q <= 16'd1;
                     gap_q       <= 16'd0;
                     state_q     <= S_GAP;
                  end else begin
                     state_q <= S_XFER;
                  end
               end else if (wd_exp_d) begin
                  abort_q <= 1'b1;
                  gap_q   <= 16'd0;
                  state_q <= S_GAP;
               end else begin
                  wd_q <= wd_inc_d;
               end
            end
            S_XFER: begin
               if (sel_vld_d) begin
                  mac_eop_q  <= sel_eop_d;
                  mac_vld_q  <= 1'b1;
                  mac_data_q <= sel_data_d;
                  len_q      <= len_inc_d;
                  wd_q       <= 16'd0;
                  if (sel_eop_d) begin
                     frame_len_q <= len_inc_d;
                     gap_q       <= 16'd0;
                     state_q     <= S_GAP;
                  end
               end else if (wd_exp_d) begin
                  abort_q <= 1'b1;
                  gap_q   <= 16'd0;
                  state_q <= S_GAP;
               end else begin
                  mac_data_q <= sel_data_d;
                  wd_q       <= wd_inc_d;
               end
            end
            S_GAP: begin
               if (gap_q == GAP_LAST) begin
                  state_q <= S_IDLE;
               end else begin
                  gap_q <= gap_q + 16'd1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign o_icmp_tx_en   = icmp_en_q;
   assign o_udp_tx_en    = udp_en_q;
   assign o_mac_txsop    = mac_sop_q;
   assign o_mac_txeop    = mac_eop_q;
   assign o_mac_txvld    = mac_vld_q;
   assign o_mac_txdata   = mac_data_q;
   assign o_tx_abort     = abort_q;
   assign o_tx_frame_len = frame_len_q;
   assign o_arb_busy     = (state_q != S_IDLE);

endmodule
